// File: rtl/i8008_pkg.sv
// ----------------------------------------------------------------------------
// i8008_pkg
// Shared encodings for the 8008 timing/state unit and scratchpad addressing:
//   - T-state codes (3 bits) driven by the timing unit
//   - machine-cycle codes (2 bits)
//   - fixed scratchpad register indices used by the address sequencer
//   - sp_sel_t: which source supplies the next scratchpad index
// ----------------------------------------------------------------------------
package i8008_pkg;

   // T-state codes
   localparam logic [2:0] WAIT    = 3'b000;
   localparam logic [2:0] T1      = 3'b010;
   localparam logic [2:0] T1I     = 3'b110;
   localparam logic [2:0] T2      = 3'b001;
   localparam logic [2:0] T3      = 3'b100;
   localparam logic [2:0] STOPPED = 3'b011;
   localparam logic [2:0] T4      = 3'b111;
   localparam logic [2:0] T5      = 3'b101;

   // Machine-cycle codes
   localparam logic [1:0] PCI = 2'b00;
   localparam logic [1:0] PCR = 2'b10;
   localparam logic [1:0] PCC = 2'b01;
   localparam logic [1:0] PCW = 2'b11;

   // Fixed scratchpad indices
   localparam logic [2:0] REG_A = 3'd0;
   localparam logic [2:0] REG_H = 3'd5;
   localparam logic [2:0] REG_L = 3'd6;

   typedef enum logic [2:0] {
      SEL_SSS,
      SEL_DDD,
      SEL_A,
      SEL_H,
      SEL_L,
      SEL_AHL,
      SEL_HOLD
   } sp_sel_t;

endpackage : i8008_pkg

// File: rtl/sp_sel_decode.sv
// ----------------------------------------------------------------------------
// sp_sel_decode
// Purely combinational decode of (T-state, machine cycle, opcode) into the
// scratchpad index source and the next-cycle scratchpad write enable.
// Ports:
//   state_i   [2:0]  current T-state code
//   cycle_i   [1:0]  current machine-cycle code
//   opcode_i  [7:0]  instruction register
//   sel_o            index source (sp_sel_t)
//   wr_en_o          write enable to be registered by the caller
// ----------------------------------------------------------------------------
module sp_sel_decode
   import i8008_pkg::*;
(
   input  logic [2:0] state_i,
   input  logic [1:0] cycle_i,
   input  logic [7:0] opcode_i,
   output sp_sel_t    sel_o,
   output logic       wr_en_o
);

   logic alu;
   logic mov;
   logic incdec;
   logic pc_rw;

   // Class-2 (op[7]) ALU ops plus the immediate forms whose op[2:1] is 01/10.
   assign alu    = ~opcode_i[6] & (opcode_i[7] | (opcode_i[2] ^ opcode_i[1]));
   assign mov    = (opcode_i[7:6] == 2'b11);
   // INr/DCr: DDD=000 (A) is excluded because that encoding is HLT.
   assign incdec = (opcode_i[7:6] == 2'b00) && (opcode_i[2:1] == 2'b00)
                   && (opcode_i[5:3] != 3'b000);
   assign pc_rw  = (cycle_i == PCR) || (cycle_i == PCW);

   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves
      // it unassigned; otherwise synthesis would infer a latch.
      sel_o   = SEL_AHL;
      wr_en_o = 1'b0;
      case (state_i)
         WAIT, STOPPED: sel_o = SEL_HOLD;
         T1:            if (pc_rw) sel_o = SEL_L;
         T2:            if (pc_rw) sel_o = SEL_H;
         T4:            sel_o = SEL_SSS;
         T5: begin
            sel_o   = alu ? SEL_A : SEL_DDD;
            wr_en_o = ~alu & (mov | incdec);
         end
         default:       sel_o = SEL_AHL;  // T3, T1I
      endcase
   end

endmodule : sp_sel_decode

// File: rtl/sp_addr_seq.sv
// ----------------------------------------------------------------------------
// sp_addr_seq
// Registered scratchpad address sequencer with a banked register file.
// The index is chosen by sp_sel_decode and registered on clk1 together with
// a write strobe. A bank prefix is loaded through a pending register and only
// becomes active at the start of the next instruction fetch (T1 of PCI), so
// an instruction in flight never sees its bank change.
// Parameters:
//   IDX_W   in-bank index width (>= 3)
//   BANK_W  bank prefix width   (>= 1)
// Ports:
//   clk1       clock, rising edge
//   rst_n      asynchronous active-low reset
//   state      T-state code
//   cycle      machine-cycle code
//   opcode     instruction register
//   ahl        fallback index from the control unit
//   bank_we    request to load a new bank
//   bank_din   bank value for bank_we
//   addr       registered {bank, index}
//   wr_en      registered scratchpad write enable
//   bank_pend  a bank load is waiting for the next fetch
// ----------------------------------------------------------------------------
module sp_addr_seq
   import i8008_pkg::*;
#(
   parameter int IDX_W  = 3,
   parameter int BANK_W = 1
) (
   input  logic                    clk1,
   input  logic                    rst_n,
   input  logic [2:0]              state,
   input  logic [1:0]              cycle,
   input  logic [7:0]              opcode,
   input  logic [IDX_W-1:0]        ahl,
   input  logic                    bank_we,
   input  logic [BANK_W-1:0]       bank_din,
   output logic [BANK_W+IDX_W-1:0] addr,
   output logic                    wr_en,
   output logic                    bank_pend
);

   if (BANK_W < 1) begin : g_bank_w_chk
      $error("sp_addr_seq: BANK_W must be at least 1");
   end
   if (IDX_W < 3) begin : g_idx_w_chk
      $error("sp_addr_seq: IDX_W must be at least 3");
   end

   sp_sel_t           sel;
   logic              wr_en_nxt;
   logic              transfer;

   logic [IDX_W-1:0]  idx_d,       idx_q;
   logic [BANK_W-1:0] bank_d,      bank_q;
   logic [BANK_W-1:0] pend_bank_d, pend_bank_q;
   logic              pend_d,      pend_q;
   logic              wr_d,        wr_q;

   sp_sel_decode u_decode (
      .state_i  (state),
      .cycle_i  (cycle),
      .opcode_i (opcode),
      .sel_o    (sel),
      .wr_en_o  (wr_en_nxt)
   );

   always_comb begin
      idx_d = ahl;
      case (sel)
         SEL_SSS:  idx_d = IDX_W'(opcode[2:0]);
         SEL_DDD:  idx_d = IDX_W'(opcode[5:3]);
         SEL_A:    idx_d = IDX_W'(REG_A);
         SEL_H:    idx_d = IDX_W'(REG_H);
         SEL_L:    idx_d = IDX_W'(REG_L);
         SEL_HOLD: idx_d = idx_q;
         default:  idx_d = ahl;
      endcase
   end

   // Hold states force the strobe low; the decoder already guarantees this.
   assign wr_d     = wr_en_nxt;
   assign transfer = (state == T1) && (cycle == PCI);

   // Deferred bank load. A write on the transfer edge bypasses the pending
   // register; otherwise the latest write sits in pending until the next fetch.
   always_comb begin
      bank_d      = bank_q;
      pend_bank_d = pend_bank_q;
      pend_d      = pend_q;
      if (transfer) begin
         pend_d = 1'b0;
         if (bank_we) begin
            bank_d = bank_din;
         end else if (pend_q) begin
            bank_d = pend_bank_q;
         end
      end else if (bank_we) begin
         pend_bank_d = bank_din;
         pend_d      = 1'b1;
      end
   end

   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         idx_q       <= '0;
         bank_q      <= '0;
         pend_bank_q <= '0;
         pend_q      <= 1'b0;
         wr_q        <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values, independent of statement order.
         idx_q       <= idx_d;
         bank_q      <= bank_d;
         pend_bank_q <= pend_bank_d;
         pend_q      <= pend_d;
         wr_q        <= wr_d;
      end
   end

   // The bank field is the active bank register itself, so a transfer edge
   // shows the new bank together with the T1 index.
   assign addr      = {bank_q, idx_q};
   assign wr_en     = wr_q;
   assign bank_pend = pend_q;

endmodule : sp_addr_seq

// File: doc/sp_addr_seq.md
# sp_addr_seq

Registered, parametrised scratchpad address sequencer for the 8008 datapath, the successor to the combinational scratchpad address mux. It decodes the current T-state, machine cycle and opcode into a scratchpad index (SSS, DDD, A, H, L or an external fallback) and registers it on `clk1`. It also generates a registered scratchpad write strobe and prefixes a bank number, so the register file can grow beyond eight entries. It sits between the timing/state unit and the scratchpad RAM.

## Interface
- `IDX_W`, default 3: width of the in-bank register index. Opcode fields are zero-extended to this width.
- `BANK_W`, default 1: width of the bank prefix. 0 is not allowed; the minimum is 1.
- `clk1`  in  1: sole clock. All state updates on its rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `state`  in  3: T-state code (from `i8008_pkg`).
- `cycle`  in  2: machine-cycle code (from `i8008_pkg`).
- `opcode`  in  8: current instruction register.
- `ahl`  in  `IDX_W`: fallback index from the control unit.
- `bank_we`  in  1: request to load a new bank.
- `bank_din`  in  `BANK_W`: bank value for `bank_we`.
- `addr`  out  `BANK_W+IDX_W`: registered scratchpad address, {bank, index}.
- `wr_en`  out  1: registered scratchpad write enable.
- `bank_pend`  out  1: a bank load is pending.

## Operation
- Decode signals:
  - alu = ~op[6] & (op[7] | (op[2]^op[1])).
  - mov = op[7:6]==11.
  - incdec = op[7:6]==00, op[2:1]==00 and op[5:3]!=000.
- Index selection, in priority order:
  1. state WAIT or STOPPED: hold index and bank; wr_en forced to 0.
  2. T1 with cycle PCR or PCW: REG_L.
  3. T2 with cycle PCR or PCW: REG_H.
  4. T4: SSS (op[2:0]).
  5. T5 with alu: REG_A.
  6. T5 with ~alu: DDD (op[5:3]).
  7. Otherwise: `ahl`.
- The next `wr_en` is 1 only when state is T5 and ~alu and (mov or incdec).
- Bank load is deferred so that the instruction in flight keeps its bank:
  - `bank_we` captures `bank_din` into a pending register and sets `bank_pend`.
  - The pending value is transferred to the active bank on the first clock edge where state==T1 and cycle==PCI. That edge also clears `bank_pend`.
  - If `bank_we` arrives while a load is already pending, the new value overwrites the pending one (last write wins).
  - If `bank_we` and the transfer condition occur on the same edge, `bank_din` becomes active directly and `bank_pend` is 0 afterwards.
- The `addr` bank field always equals the active bank register as it is after that edge. On a transfer edge, the new bank therefore appears with the T1 index.

## Timing
- Latency: `addr` and `wr_en` reflect the inputs sampled at clock edge N, and are valid from edge N until edge N+1.
- There is no combinational path from any input to any output.
- `rst_n` low, at any time and including mid-instruction, immediately clears the following:
  - `addr`=0
  - `wr_en`=0
  - active bank=0
  - pending bank=0
  - `bank_pend`=0
- After reset deasserts, the first edge resumes the normal decode.
- A hold state lasting any number of cycles leaves `addr` unchanged. The next non-hold state decodes normally.
- An undefined state code (T1I included) selects `ahl` and gives wr_en=0.

## Structure
- `i8008_pkg` holds:
  - state codes: WAIT=000, T1=010, T1I=110, T2=001, T3=100, STOPPED=011, T4=111, T5=101
  - cycle codes: PCI=00, PCR=10, PCC=01, PCW=11
  - register indices: REG_A=0, REG_H=5, REG_L=6
  - an `sp_sel_t` enum {SEL_SSS, SEL_DDD, SEL_A, SEL_H, SEL_L, SEL_AHL, SEL_HOLD}
- One sub-module, `sp_sel_decode`, is purely combinational and maps (state, cycle, opcode) to `sp_sel_t` plus the next wr_en.
- The top level holds the registers and the bank logic.

## Test plan
- Reset: `rst_n`=0 mid-T4 gives addr=0, wr_en=0 and bank_pend=0 in the same cycle. With `rst_n`=1, T4 and op=0xC1 give addr=1 after one edge.
- MOV 0xC1 (ddd=0, sss=1):
  - T4 gives addr=1 and wr_en=0 at the next edge.
  - T5 gives addr=0 and wr_en=1.
- ALU ADD B 0x81:
  - T4 gives addr=1.
  - T5 gives addr=REG_A=0 with wr_en=0.
- PCR cycle:
  - T1 gives addr=6.
  - T2 gives addr=5.
  - Three WAIT cycles keep addr=5 with wr_en=0.
  - T3 with ahl=3 gives addr=3.
- Bank deferral (BANK_W=1):
  - bank_we=1 with bank_din=1 during T4 gives bank_pend=1, and addr[3] stays 0 through T5.
  - The next T1/PCI gives addr={1,ahl} and bank_pend=0.
- Collisions:
  - Two consecutive bank_we writes (1, then 0) before T1/PCI leave active bank=0.
  - bank_we=1 on the T1/PCI edge itself gives an immediate addr[3]=1 and bank_pend=0.
